// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline register built as a two-entry skid buffer: main entry drives decode, skid absorbs one beat of stall.
// Latency 1 cycle; up_ready is a function of registered occupancy plus hold/flush only, never of dn_ready.
module if_id_skid_stage #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = 32'h0000_0013,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [ADDR_W-1:0] up_pc,
  input  logic [INST_W-1:0] up_inst,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [ADDR_W-1:0] dn_pc,
  output logic [INST_W-1:0] dn_inst,
  input  logic              flush,
  input  logic              hold,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;

  logic stage_live;
  logic acc;
  logic pop;

  // Both handshake signals are gated by the control inputs so hold/flush cycles can never transfer.
  assign stage_live = ~rst & ~flush & ~hold;
  assign up_ready   = stage_live & (state_q != S_FULL);
  assign dn_valid   = stage_live & (state_q != S_EMPTY);

  assign acc = up_valid & up_ready;
  assign pop = dn_valid & dn_ready;

  assign dn_pc   = main_pc_q;
  assign dn_inst = main_inst_q;
  assign count   = state_q;

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;

    if (flush) begin
      state_d     = S_EMPTY;
      main_pc_d   = RESET_PC;
      main_inst_d = NOP_INST;
      skid_pc_d   = RESET_PC;
      skid_inst_d = NOP_INST;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (acc) begin
            state_d     = S_ONE;
            main_pc_d   = up_pc;
            main_inst_d = up_inst;
          end
        end
        S_ONE: begin
          unique case ({acc, pop})
            2'b11: begin
              main_pc_d   = up_pc;
              main_inst_d = up_inst;
            end
            2'b10: begin
              state_d     = S_FULL;
              skid_pc_d   = up_pc;
              skid_inst_d = up_inst;
            end
            2'b01: begin
              // Drained: decode sees a NOP rather than a stale instruction.
              state_d     = S_EMPTY;
              main_pc_d   = RESET_PC;
              main_inst_d = NOP_INST;
            end
            default: ;
          endcase
        end
        S_FULL: begin
          if (pop) begin
            state_d     = S_ONE;
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
          end
        end
        default: begin
          state_d     = S_EMPTY;
          main_pc_d   = RESET_PC;
          main_inst_d = NOP_INST;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_pc_q   <= RESET_PC;
      main_inst_q <= NOP_INST;
      skid_pc_q   <= RESET_PC;
      skid_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  // Occupancy 3 is unreachable, and an empty stage always presents the NOP pair.
  a_no_count3: assert property (@(posedge clk) disable iff (rst) state_q != 2'd3);
  a_empty_nop: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_EMPTY) |-> (main_inst_q == NOP_INST && main_pc_q == RESET_PC));

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: queue-based occupancy model checked every cycle plus hand-computed literals.
module tb_if_id_skid_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_valid;
  logic        up_ready;
  logic [31:0] up_pc;
  logic [31:0] up_inst;
  logic        dn_valid;
  logic        dn_ready;
  logic [31:0] dn_pc;
  logic [31:0] dn_inst;
  logic        flush;
  logic        hold;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [63:0] mq[$];

  if_id_skid_stage dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_pc(up_pc), .up_inst(up_inst),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_pc(dn_pc), .dn_inst(dn_inst),
    .flush(flush), .hold(hold), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0593};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic uv, input logic [31:0] pc, input logic dr,
                       input logic fl, input logic hd);
    up_valid = uv;
    up_pc    = pc;
    up_inst  = inst_of(pc);
    dn_ready = dr;
    flush    = fl;
    hold     = hd;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: a FIFO of at most two {pc,inst} entries, popped before pushed in each live cycle.
  always @(posedge clk) begin
    int n;
    n = mq.size();
    if (rst || flush) begin
      mq.delete();
    end else if (!hold) begin
      if (n > 0 && dn_ready) void'(mq.pop_front());
      if (up_valid && n < 2) mq.push_back({up_pc, up_inst});
    end
  end

  always @(negedge clk) begin
    logic        live;
    logic [63:0] head;
    if (chk_en) begin
      live = !rst && !flush && !hold;
      head = (mq.size() > 0) ? mq[0] : {RPC, NOP};
      chk("m_count",    count,    mq.size());
      chk("m_dn_valid", dn_valid, live && mq.size() > 0);
      chk("m_up_ready", up_ready, live && mq.size() < 2);
      chk("m_dn_pc",    dn_pc,    head[63:32]);
      chk("m_dn_inst",  dn_inst,  head[31:0]);
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b1, 32'h99, 1'b1, 1'b0, 1'b0);
    tick;
    chk_en = 1'b1;
    tick;
    chk("rst_count",    count,    0);
    chk("rst_dn_valid", dn_valid, 0);
    chk("rst_up_ready", up_ready, 0);
    chk("rst_dn_inst",  dn_inst,  32'h13);
    chk("rst_dn_pc",    dn_pc,    0);

    // Streaming
    rst = 1'b0;
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("rel_up_ready", up_ready, 1);
    tick;
    drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0);
    chk("str0_dn_valid", dn_valid, 1);
    chk("str0_dn_pc",    dn_pc,    32'h0);
    chk("str0_dn_inst",  dn_inst,  32'h0000_0593);
    chk("str0_count",    count,    1);
    tick;
    drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
    chk("str1_dn_pc",    dn_pc,    32'h4);
    chk("str1_up_ready", up_ready, 1);
    tick;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("str2_dn_pc",    dn_pc,    32'h8);
    chk("str2_count",    count,    1);
    tick;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("str_end_count",   count,   0);
    chk("str_end_dn_inst", dn_inst, 32'h13);

    // Backpressure
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
    chk("bp_count1", count, 1);
    tick;
    drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b0);
    chk("bp_count2",   count,    2);
    chk("bp_up_ready", up_ready, 0);
    chk("bp_model2",   mq.size(), 2);
    tick;
    drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
    chk("bp_full_pc", dn_pc,    32'h0);
    chk("bp_full_rdy", up_ready, 0);
    tick;
    drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
    chk("bp_pop1_pc",  dn_pc,    32'h4);
    chk("bp_pop1_rdy", up_ready, 1);
    chk("bp_pop1_cnt", count,    1);
    tick;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("bp_acc8_pc", dn_pc, 32'h8);
    tick;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("bp_end_count", count, 0);

    // Flush while FULL with a pending input
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b1, 32'h18, 1'b0, 1'b1, 1'b0);
    chk("fl_count2",   count,    2);
    chk("fl_up_ready", up_ready, 0);
    chk("fl_dn_valid", dn_valid, 0);
    tick;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("fl_count0",   count,    0);
    chk("fl_dn_valid0", dn_valid, 0);
    chk("fl_dn_inst",  dn_inst,  32'h13);
    tick;

    // Hold with one entry, then simultaneous acc+pop on release
    drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h24, 1'b1, 1'b0, 1'b1);
      chk("hd_dn_valid", dn_valid, 0);
      chk("hd_up_ready", up_ready, 0);
      chk("hd_count",    count,    1);
      chk("hd_dn_pc",    dn_pc,    32'h20);
      tick;
    end
    drive(1'b1, 32'h24, 1'b1, 1'b0, 1'b0);
    chk("hd_rel_valid", dn_valid, 1);
    chk("hd_rel_pc",    dn_pc,    32'h20);
    tick;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("sim_count", count, 1);
    chk("sim_dn_pc", dn_pc, 32'h24);
    tick;

    // Flush together with hold
    drive(1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flhd_count", count,     0);
    chk("flhd_model", mq.size(), 0);

    // Hold mid-stall while FULL
    drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b1, 32'h48, 1'b1, 1'b0, 1'b1);
    tick;
    tick;
    drive(1'b1, 32'h48, 1'b1, 1'b0, 1'b0);
    chk("hf_count", count, 2);
    chk("hf_dn_pc", dn_pc, 32'h40);
    tick;
    drive(1'b1, 32'h48, 1'b1, 1'b0, 1'b0);
    chk("hf_pop_pc", dn_pc, 32'h44);
    tick;

    // Mixed control pattern, checked by the model every cycle
    for (int i = 0; i < 48; i++) begin
      drive((i % 3) != 2, 32'h100 + 32'(4 * i), (i % 5) != 0 && (i % 11) != 4,
            i == 17 || i == 38, (i % 7) == 3);
      tick;
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick;
    chk("drain_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_skid_stage.md
# if_id_skid_stage

Parametrised IF→ID pipeline stage: a two-entry skid buffer with a valid/ready handshake, synchronous flush and hold. It replaces the fixed 32-bit PC/instruction flop pair between the fetch and decode units. Because it holds two entries, fetch can keep streaming while decode stalls, and the upstream ready is a registered occupancy state, so no combinational ready path runs from decode back to fetch. Flushed or empty slots present a NOP to decode.

## Interface
- ADDR_W, 32, PC width in bits
- INST_W, 32, instruction width in bits
- NOP_INST, 32'h0000_0013, instruction value presented when the stage is empty, flushed or reset (addi x0,x0,0)
- RESET_PC, 0, PC value presented when the stage is empty, flushed or reset

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active-high
- up_valid  in  1  fetch presents a PC/instruction pair
- up_ready  out  1  stage can accept; up_ready = (count != 2) & ~hold & ~flush
- up_pc  in  ADDR_W  fetch PC
- up_inst  in  INST_W  fetch instruction
- dn_valid  out  1  main entry valid for decode; dn_valid = (count != 0) & ~hold & ~flush
- dn_ready  in  1  decode accepts
- dn_pc  out  ADDR_W  main-entry PC (registered)
- dn_inst  out  INST_W  main-entry instruction (registered)
- flush  in  1  from ctrl; discards all entries
- hold  in  1  from ctrl; freezes the stage
- count  out  2  occupancy: 0, 1 or 2

## Operation
- Storage: a main register, which drives dn_*, and a skid register. States are EMPTY (count 0), ONE (count 1) and FULL (count 2).
- Transfer conditions: acc = up_valid & up_ready; pop = dn_valid & dn_ready.
- EMPTY:
  - acc → ONE; main ← up.
- ONE:
  - acc & pop → ONE; main ← up.
  - acc & ~pop → FULL; skid ← up.
  - pop & ~acc → EMPTY; main ← {RESET_PC, NOP_INST}.
  - neither → ONE, no change.
- FULL:
  - up_ready = 0.
  - pop → ONE; main ← skid.
  - otherwise → FULL, no change.
- Entries leave in acceptance order. The skid entry is never presented ahead of the main entry.
- Priority: rst > flush > hold > normal operation.
- rst or flush: state → EMPTY; main ← {RESET_PC, NOP_INST}; skid ← {RESET_PC, NOP_INST}.
  - In a flush cycle up_ready = 0 and dn_valid = 0, so nothing is accepted or popped. Any up_valid in that cycle is dropped.
- hold: up_ready = 0 and dn_valid = 0, so no transfers occur.
  - State, count and both registers are preserved.
  - dn_pc/dn_inst keep showing the main entry.
- When count = 0, dn_pc = RESET_PC and dn_inst = NOP_INST.
- Width rules: data passes through unmodified with no truncation or extension. count is exactly 2 bits; the value 3 is unreachable.

## Timing
- Reset values: count = 0, dn_valid = 0, up_ready = 0 while rst is high, dn_pc = RESET_PC, dn_inst = NOP_INST.
- up_ready = 1 in the first cycle after rst deasserts, provided flush and hold are low.
- Latency: data accepted at edge N appears on dn_* with dn_valid = 1 in the cycle after edge N (1 cycle).
- Throughput: one transfer per cycle when dn_ready is held high.
- Ready path: up_ready depends only on registered count plus the hold and flush controls. It never depends on dn_ready in the same cycle.
- Stall absorption: when dn_ready drops, at most one further beat is absorbed, into the skid register. up_ready falls in the cycle after count reaches 2.
- Draining from FULL: the first pop returns to ONE and up_ready rises in the next cycle. A second pop with no accept reaches EMPTY.
- Flush while FULL: both entries are gone at the next edge. dn_inst = NOP_INST in the following cycle.
- hold raised or dropped mid-stall: no entry is lost or duplicated. After hold drops, count and data continue from the held state.

## Test plan
- Reset: assert rst for 2 cycles with up_valid = 1 → count = 0, dn_valid = 0, dn_inst = 32'h13, dn_pc = 0. up_ready = 1 in the cycle after release.
- Streaming: dn_ready = 1; feed PCs 0x0, 0x4, 0x8 with instructions A, B, C on consecutive cycles → each appears one cycle later in order. count stays at 1 and up_ready stays at 1.
- Backpressure: hold dn_ready = 0 and feed 0x0, 0x4, 0x8 → count goes 1 then 2. up_ready = 0 in the cycle after count reaches 2, and 0x8 is not accepted. Release dn_ready → 0x0 then 0x4 pop on successive cycles; 0x8 is accepted once up_ready returns.
- Flush: with count = 2 (0x10, 0x14) and up_valid = 1 carrying 0x18, pulse flush → next cycle count = 0, dn_valid = 0, dn_inst = 32'h13, and 0x18 is never output.
- Hold: with count = 1 (0x20), assert hold for 3 cycles while up_valid = 1 and dn_ready = 1 → dn_valid = 0, up_ready = 0, count = 1, dn_pc = 0x20 throughout. After release, 0x20 pops and the pending input is accepted.
- Simultaneous: in state ONE with acc and pop in the same cycle → count stays 1 and main holds the new entry. flush together with hold → flush wins and count = 0.
